// File: rtl/activation_unit_if.sv
// Bundles the activation unit's control handshake and feature-map buses.
// Ports: start/mode in, in_feature_flat in, out_feature_flat out, busy/done out.
// master = the side that launches passes and supplies the map; slave = the unit.
interface activation_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TOTAL      = 8 * 28 * 28
);
  logic                        start;
  logic [1:0]                  mode;
  logic [DATA_WIDTH*TOTAL-1:0] in_feature_flat;
  logic [DATA_WIDTH*TOTAL-1:0] out_feature_flat;
  logic                        busy;
  logic                        done;

  modport master (
    output start, mode, in_feature_flat,
    input  out_feature_flat, busy, done
  );

  modport slave (
    input  start, mode, in_feature_flat,
    output out_feature_flat, busy, done
  );
endinterface

// File: rtl/activation_unit.sv
// Multi-lane activation layer: sweeps one flat feature map LANES elements per
// cycle, applying RELU / LEAKY / RELU6 / PASS (latched at start), then pulses done.
// Ports: clk, reset (sync, active-high), bus (slave: start, mode, in/out maps, busy, done).
module activation_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 7,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  activation_unit_if.slave  bus
);

  localparam int TOTAL  = CHANNELS * IMG_SIZE * IMG_SIZE;
  // idx + lane offset can reach TOTAL + LANES - 2 on the tail beat.
  localparam int IDX_W  = $clog2(TOTAL + LANES + 1);
  localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  // RELU6 ceiling: 6.0 in Q format, saturated to the largest positive value.
  localparam longint C6_RAW  = longint'(6) << FRAC_BITS;
  localparam longint POS_MAX = (longint'(1) << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [DATA_WIDTH-1:0] C6 =
    DATA_WIDTH'((C6_RAW < POS_MAX) ? C6_RAW : POS_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    M_RELU  = 2'd0,
    M_LEAKY = 2'd1,
    M_RELU6 = 2'd2,
    M_PASS  = 2'd3
  } mode_t;

  state_t                         state;
  mode_t                          mode_q;
  logic [IDX_W-1:0]               idx;
  logic                           busy_q;
  logic                           done_q;
  logic signed [DATA_WIDTH-1:0]   out_q [TOTAL];

  logic [IDX_W-1:0]               lane_idx  [LANES];
  logic                           lane_ok   [LANES];
  logic [ADDR_W-1:0]              lane_addr [LANES];
  logic signed [DATA_WIDTH-1:0]   lane_val  [LANES];
  logic                           last_beat;

  function automatic logic signed [DATA_WIDTH-1:0] act(
    input logic signed [DATA_WIDTH-1:0] x,
    input mode_t                        m
  );
    logic signed [DATA_WIDTH-1:0] y;
    y = x;
    case (m)
      M_RELU:  if (x[DATA_WIDTH-1]) y = '0;
      // Arithmetic shift floors toward -inf, so small negatives settle at -1.
      M_LEAKY: if (x[DATA_WIDTH-1]) y = x >>> LEAK_SHIFT;
      M_RELU6: begin
        if (x[DATA_WIDTH-1]) y = '0;
        else if (x > C6)     y = C6;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  // Per-lane element address and activated value for the current beat.
  // Tail lanes past the map end are flagged invalid and their address parked
  // at 0 so the input select never leaves the bus.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l]  = idx + IDX_W'(l);
      lane_ok[l]   = (lane_idx[l] < IDX_W'(TOTAL));
      lane_addr[l] = lane_ok[l] ? lane_idx[l][ADDR_W-1:0] : '0;
      lane_val[l]  = act(bus.in_feature_flat[int'(lane_addr[l])*DATA_WIDTH +: DATA_WIDTH],
                         mode_q);
    end
  end

  assign last_beat = ((idx + IDX_W'(LANES)) >= IDX_W'(TOTAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_q <= M_RELU;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q <= mode_t'(bus.mode);
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_ok[l]) begin
              out_q[lane_addr[l]] <= lane_val[l];
            end
          end
          if (last_beat) begin
            state <= S_FINISH;
          end else begin
            idx <= idx + IDX_W'(LANES);
          end
        end
        S_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < TOTAL; g++) begin : g_flat
    assign bus.out_feature_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
